// File: rtl/pls_otg_hpi_pkg.sv
// Shared types and constants for the Avalon-MM to HPI bridge controller.
package pls_otg_hpi_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } hpi_state_t;

  localparam logic [1:0] HPI_ADDR_DATA    = 2'd0;
  localparam logic [1:0] HPI_ADDR_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/pls_otg_hpi_ctrl.sv
// Avalon-MM slave to Cypress-style HPI bus timing controller (setup/strobe/hold).
// Optional interrupt pass-through with 2-flop synchronizer: define PLS_OTG_HPI_IRQ_EN.
module pls_otg_hpi_ctrl
  import pls_otg_hpi_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
`ifdef PLS_OTG_HPI_IRQ_EN
  input  logic        otg_hpi_int,
  output logic        irq,
`endif
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [1:0]  otg_hpi_address,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
      STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
    $error("pls_otg_hpi_ctrl: phase lengths must be within 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  hpi_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q;
  logic [1:0]       addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             req;
  logic             latch;
  logic             active;
  logic             rd_capture;

  assign req = chipselect & (~read_n | ~write_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each phase loads its length minus one and advances when the counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          latch   = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A simultaneous read+write request resolves to a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch) begin
      wr_q    <= ~write_n;
      addr_q  <= address;
      wdata_q <= writedata;
    end
  end

  assign rd_capture = (state_q == ST_STROBE) && (cnt_q == '0) && !wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (rd_capture) begin
      rdata_q <= otg_hpi_data_in;
    end
  end

  assign active = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);

  assign otg_hpi_cs_n     = ~active;
  assign otg_hpi_r_n      = ~((state_q == ST_STROBE) && !wr_q);
  assign otg_hpi_w_n      = ~((state_q == ST_STROBE) && wr_q);
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_data_out = wdata_q;
  assign otg_hpi_data_oe  = active & wr_q;
  assign readdata         = rdata_q;
  assign waitrequest      = req & (state_q != ST_DONE);

`ifdef PLS_OTG_HPI_IRQ_EN
  logic irq_meta_q, irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_meta_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_meta_q <= otg_hpi_int;
      irq_q      <= irq_meta_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pls_otg_hpi_ctrl.sv
// Scoreboard bench for pls_otg_hpi_ctrl: HPI bus monitor checks each completed transfer.
module tb_pls_otg_hpi_ctrl;

  localparam int SETUP  = 1;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int LAT    = SETUP + STROBE + HOLD + 2;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        waitrequest;
  logic        otg_hpi_cs_n;
  logic        otg_hpi_r_n;
  logic        otg_hpi_w_n;
  logic [1:0]  otg_hpi_address;
  logic [15:0] otg_hpi_data_out;
  logic        otg_hpi_data_oe;
  logic [15:0] otg_hpi_data_in;
  logic [15:0] pad_val;
`ifdef PLS_OTG_HPI_IRQ_EN
  logic        otg_hpi_int;
  logic        irq;
`endif

  pls_otg_hpi_ctrl #(
    .SETUP_CYCLES (SETUP),
    .STROBE_CYCLES(STROBE),
    .HOLD_CYCLES  (HOLD)
  ) dut (
`ifdef PLS_OTG_HPI_IRQ_EN
    .otg_hpi_int     (otg_hpi_int),
    .irq             (irq),
`endif
    .clk             (clk),
    .reset_n         (reset_n),
    .address         (address),
    .chipselect      (chipselect),
    .read_n          (read_n),
    .write_n         (write_n),
    .writedata       (writedata),
    .readdata        (readdata),
    .waitrequest     (waitrequest),
    .otg_hpi_cs_n    (otg_hpi_cs_n),
    .otg_hpi_r_n     (otg_hpi_r_n),
    .otg_hpi_w_n     (otg_hpi_w_n),
    .otg_hpi_address (otg_hpi_address),
    .otg_hpi_data_out(otg_hpi_data_out),
    .otg_hpi_data_oe (otg_hpi_data_oe),
    .otg_hpi_data_in (otg_hpi_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pad only presents valid data while the read strobe is low.
  assign otg_hpi_data_in = (!otg_hpi_r_n) ? pad_val : 16'hDEAD;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] rd_model = 16'h0000;

  int  lat, cs_cnt, wn_cnt, rn_cnt, oe_cnt, strb_first, cs_hi_run;
  bit  gap_valid;
  logic [1:0]  addr_seen;
  logic [15:0] dout_seen;

  task automatic mon_clear();
    lat = 0; cs_cnt = 0; wn_cnt = 0; rn_cnt = 0; oe_cnt = 0; strb_first = -1;
    addr_seen = 2'bxx; dout_seen = 16'hxxxx;
  endtask

  initial begin
    mon_clear();
    cs_hi_run = 0;
    gap_valid = 1'b0;
  end

  // Bus monitor: accumulate one transfer's observations, compare on completion.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_clear();
      gap_valid = 1'b0;
      cs_hi_run = 0;
    end else begin
      logic req;
      exp_t e;
      req = chipselect & (~read_n | ~write_n);
      if (req) lat++;
      if (!otg_hpi_cs_n) begin
        if (cs_cnt == 0 && gap_valid) chk("cs_gap_ge2", (cs_hi_run >= 2), 1);
        cs_cnt++;
        addr_seen = otg_hpi_address;
        cs_hi_run = 0;
      end else begin
        cs_hi_run++;
      end
      if (!otg_hpi_w_n || !otg_hpi_r_n) begin
        if (strb_first < 0) strb_first = lat - 1;
      end
      if (!otg_hpi_w_n) wn_cnt++;
      if (!otg_hpi_r_n) rn_cnt++;
      if (otg_hpi_data_oe) begin
        oe_cnt++;
        dout_seen = otg_hpi_data_out;
      end
      if (req && !waitrequest) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", lat, LAT);
          chk("cs_low_cycles", cs_cnt, SETUP + STROBE + HOLD);
          chk("strobe_start", strb_first, SETUP + 1);
          chk("hpi_addr", addr_seen, e.addr);
          chk("readdata", readdata, e.rdata);
          if (e.wr) begin
            chk("w_n_cycles", wn_cnt, STROBE);
            chk("r_n_cycles", rn_cnt, 0);
            chk("oe_cycles", oe_cnt, SETUP + STROBE + HOLD);
            chk("data_out", dout_seen, e.wdata);
          end else begin
            chk("r_n_cycles", rn_cnt, STROBE);
            chk("w_n_cycles", wn_cnt, 0);
            chk("oe_cycles", oe_cnt, 0);
          end
        end
        mon_clear();
        gap_valid = 1'b1;
      end
    end
  end

  // Drive one Avalon request (called just after a rising edge) and wait for completion.
  task automatic xfer(input bit rd, input bit wr, input logic [1:0] a,
                      input logic [15:0] d, input logic [15:0] pad, input bit release_bus);
    exp_t e;
    bit   done;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    if (!wr) rd_model = pad;
    e.rdata = rd_model;
    sb_q.push_back(e);
    pad_val    = pad;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    read_n     = ~rd;
    write_n    = ~wr;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
    end
    if (!done) chk("xfer_timeout", 0, 1);
    @(posedge clk); #1;
    if (release_bus) begin
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 16'h0;
    pad_val    = 16'h0;
`ifdef PLS_OTG_HPI_IRQ_EN
    otg_hpi_int = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", otg_hpi_cs_n, 1);
    chk("rst_r_n", otg_hpi_r_n, 1);
    chk("rst_w_n", otg_hpi_w_n, 1);
    chk("rst_oe", otg_hpi_data_oe, 0);
    chk("rst_addr", otg_hpi_address, 0);
    chk("rst_dout", otg_hpi_data_out, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_wait_idle", waitrequest, 0);
    chipselect = 1'b1; write_n = 1'b0;
    #1;
    chk("rst_wait_req", waitrequest, 1);
    chipselect = 1'b0; write_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    xfer(1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000, 1'b1);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 1'b1);
    @(posedge clk); #1;
    xfer(1'b1, 1'b1, 2'd1, 16'hA5C3, 16'h7777, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    xfer(1'b0, 1'b1, 2'd3, 16'h0F0F, 16'h0000, 1'b0);
    xfer(1'b0, 1'b1, 2'd1, 16'hF0F0, 16'h0000, 1'b1);
    xfer(1'b1, 1'b0, 2'd3, 16'h0000, 16'h1357, 1'b0);
    xfer(1'b1, 1'b0, 2'd2, 16'h0000, 16'h2468, 1'b1);
    for (int k = 0; k < 6; k++) begin
      bit r;
      r = $urandom_range(0, 1);
      xfer(r, ~r, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    address = 2'd1; writedata = 16'hCAFE;
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!otg_hpi_w_n) seen = 1'b1;
    end
    chk("abort_reach_strobe", seen, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("abort_cs_n", otg_hpi_cs_n, 1);
    chk("abort_w_n", otg_hpi_w_n, 1);
    chk("abort_oe", otg_hpi_data_oe, 0);
    chk("abort_dout", otg_hpi_data_out, 0);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #2;
    reset_n = 1'b1;
    rd_model = 16'h0000;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_pending", sb_q.size(), 0);
    chk("abort_readdata", readdata, 0);

    xfer(1'b1, 1'b0, 2'd0, 16'h0000, 16'h55AA, 1'b1);
    @(posedge clk); #1;

`ifdef PLS_OTG_HPI_IRQ_EN
    otg_hpi_int = 1'b1;
    @(negedge clk);
    chk("irq_cycle0", irq, 0);
    @(negedge clk);
    chk("irq_cycle1", irq, 0);
    @(negedge clk);
    chk("irq_cycle2", irq, 1);
    otg_hpi_int = 1'b0;
    repeat (3) @(negedge clk);
    chk("irq_fall", irq, 0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pls_otg_hpi_ctrl.md
PLS_OTG_HPI_CTRL -- requirements
Module: pls_otg_hpi_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- SETUP_CYCLES, default 1: cycles with cs_n/address valid before the strobe.
- STROBE_CYCLES, default 4: cycles with r_n/w_n low.
- HOLD_CYCLES, default 1: cycles after the strobe with cs_n still low.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be as follows:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- address  in  2  Avalon-MM slave word address, passed to HPI.
- chipselect  in  1  Avalon slave select.
- read_n  in  1  Avalon read, active-low.
- write_n  in  1  Avalon write, active-low.
- writedata  in  16  Avalon write data.
- readdata  out  16  registered HPI read data.
- waitrequest  out  1  Avalon stall.
- otg_hpi_cs_n  out  1  HPI chip select.
- otg_hpi_r_n  out  1  HPI read strobe.
- otg_hpi_w_n  out  1  HPI write strobe.
- otg_hpi_address  out  2  HPI register select.
- otg_hpi_data_out  out  16  HPI write data.
- otg_hpi_data_oe  out  1  tri-state enable for the data pad.
- otg_hpi_data_in  in  16  HPI read data from the pad.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD and DONE, with a 4-bit down-counter timing each phase.
REQ-005 In IDLE, chipselect & (~read_n | ~write_n) SHALL latch address, writedata and direction on that edge, then move to SETUP.
REQ-006 If read_n and write_n are both low, the request SHALL be a write.
REQ-007 SETUP, STROBE and HOLD SHALL each last exactly their parameter in cycles, then advance.
REQ-008 HOLD SHALL be followed by DONE (one cycle) and then IDLE.
REQ-009 otg_hpi_cs_n SHALL be low in SETUP, STROBE and HOLD, and high in IDLE and DONE.
REQ-010 otg_hpi_r_n (read) or otg_hpi_w_n (write) SHALL be low only in STROBE.
REQ-011 otg_hpi_address SHALL hold the latched address from SETUP through HOLD.
REQ-012 otg_hpi_data_oe SHALL be high for writes in SETUP, STROBE and HOLD, and low otherwise.
REQ-013 otg_hpi_data_out SHALL hold the latched writedata.
REQ-014 readdata SHALL capture otg_hpi_data_in on the clock edge ending the last STROBE cycle of a read, and hold until the next read.
REQ-015 waitrequest SHALL be high whenever chipselect & (~read_n | ~write_n) and the state is not DONE, and low in DONE.
REQ-016 The Avalon transfer SHALL complete in DONE.
REQ-017 Total latency SHALL be SETUP+STROBE+HOLD+2 cycles from request to completion (defaults: 8).
REQ-018 A request held through DONE SHALL NOT restart a transfer in that cycle.
REQ-019 The earliest next transfer SHALL begin from IDLE the following cycle, guaranteeing at least 2 cs_n-high cycles between transfers.
REQ-020 Changes to Avalon inputs while not in IDLE SHALL be ignored.
REQ-021 Parameter values of 0 or greater than 15 SHALL fail elaboration.

Reset
REQ-022 reset_n low SHALL immediately force state=IDLE, cs_n=r_n=w_n=1, data_oe=0, address=0, data_out=0 and readdata=0.
REQ-023 waitrequest SHALL follow REQ-015 during reset.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer without completing it on the Avalon side.

Configuration
REQ-025 With PLS_OTG_HPI_IRQ_EN defined, the block SHALL add input otg_hpi_int and output irq.
REQ-026 irq SHALL be otg_hpi_int through a 2-flop synchronizer reset to 0, so irq follows the pin after 2 cycles.
REQ-027 Without PLS_OTG_HPI_IRQ_EN, neither port SHALL exist and no synchronizer logic SHALL be present.

Structure
REQ-028 Package pls_otg_hpi_pkg SHALL hold the state enum type, the HPI register address constants (DATA=0, MAILBOX=1, ADDRESS=2, STATUS=3) and the counter width.
REQ-029 The block SHALL be a single module with no sub-modules; the pad tri-state stays at top level.

Verification
REQ-030 Write, defaults, address=2, writedata=0x1234 SHALL give: cs_n low 6 cycles, w_n low cycles 2-5, data_oe high with data_out=0x1234, waitrequest low in cycle 7 only.
REQ-031 Read, address=0, otg_hpi_data_in=0xBEEF during STROBE SHALL give readdata=0xBEEF at DONE, r_n low 4 cycles and data_oe 0 throughout.
REQ-032 read_n=write_n=0 together SHALL produce a write: w_n pulses and r_n stays 1.
REQ-033 Two back-to-back writes SHALL show cs_n high for at least 2 cycles between them and a second latency of 8.
REQ-034 reset_n pulsed low during STROBE of a write SHALL drive cs_n and w_n high asynchronously and never assert DONE.
REQ-035 With PLS_OTG_HPI_IRQ_EN, otg_hpi_int rising at cycle 10 SHALL give irq high at cycle 12.
